// File: rtl/fa_exerciser.sv
// fa_exerciser: sweeps all 8 A/B/Cin vectors into a full-adder cell and checks Sout/Cout after a settle time.
// Optional FA_EXERCISER_SYNC_EN: two-flop synchronizer on s_in/cout_in, settle window extended by 2 cycles.
module fa_exerciser #(
  parameter int SETTLE_CYCLES = 4,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  output logic             cin_out,
  input  logic             s_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       vec_idx,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

`ifdef FA_EXERCISER_SYNC_EN
  localparam int RELOAD = SETTLE_CYCLES + 1;
`else
  localparam int RELOAD = SETTLE_CYCLES - 1;
`endif
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 2);
  localparam int LOOP_W = (LOOPS < 2) ? 1 : $clog2(LOOPS);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(RELOAD);
  localparam logic [LOOP_W-1:0] LOOP_LAST  = LOOP_W'((LOOPS == 0) ? 0 : LOOPS - 1);

  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("fa_exerciser: SETTLE_CYCLES must be >= 1");
  end

  state_e            state_q, state_d;
  logic [2:0]        vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fv_q, fv_d;
  logic [2:0]        fvec_q, fvec_d;
  logic              s_cmp, c_cmp;
  logic              exp_s, exp_c, mismatch;

`ifdef FA_EXERCISER_SYNC_EN
  logic [1:0] s_sync_q, c_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_sync_q <= '0;
      c_sync_q <= '0;
    end else begin
      s_sync_q <= {s_sync_q[0], s_in};
      c_sync_q <= {c_sync_q[0], cout_in};
    end
  end

  assign s_cmp = s_sync_q[1];
  assign c_cmp = c_sync_q[1];
`else
  assign s_cmp = s_in;
  assign c_cmp = cout_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    loop_d   = loop_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fvec_d   = fvec_q;
    exp_s    = ^vec_q;
    exp_c    = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    mismatch = (s_cmp != exp_s) || (c_cmp != exp_c);
    case (state_q)
      // start is honoured only when no run is in flight
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_RELOAD;
          loop_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (vec_q != 3'd7) begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end else if (LOOPS == 0 || loop_q < LOOP_LAST) begin
          loop_d  = loop_q + 1'b1;
          vec_d   = '0;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {a_out, b_out, cin_out} = vec_q;
  assign vec_idx    = vec_q;
  assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: doc/fa_exerciser.md
# fa_exerciser

Self-checking stimulus driver and response checker for the ripple-carry full-adder cells (`fa_RC` family). It drives A/B/Cin into a full-adder cell and samples its Sout/Cout outputs after a programmable settle time. It compares each sample against the ideal full-adder truth table and reports error statistics. It replaces hand-written stimulus generators and `$display` inspection in cell-level benches, and it serves as an on-chip built-in self-test (BIST) engine for neuron adder slices.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range ≥1, enforced at elaboration.
- LOOPS, 1, number of full 8-vector sweeps per run; 0 = run continuously until reset.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle run request.
- a_out  out  1  drives DUT A.
- b_out  out  1  drives DUT B.
- cin_out  out  1  drives DUT Cin.
- s_in  in  1  DUT Sout.
- cout_in  in  1  DUT Cout/Caout.
- busy  out  1  run in progress.
- done  out  1  run finished; held high until the next start or rst.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  ERR_W  mismatching samples; saturating.
- vec_idx  out  3  current vector, {a_out,b_out,cin_out}.
- fail_valid  out  1  at least one mismatch seen this run.
- fail_vec  out  3  vec_idx of the first mismatch in this run.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset values: all outputs 0; state IDLE; internal loop and settle counters 0.
- IDLE:
  - start=1 → SETTLE.
  - On that transition: vec_idx=0, drive outputs 0/0/0, settle counter = SETTLE_CYCLES-1, err_cnt, fail_valid and fail_vec cleared, loop counter = 0, busy=1.
- SETTLE: counter decrements each cycle; at 0 → SAMPLE.
- SAMPLE:
  - Expected sum = a^b^cin; expected carry = majority(a,b,cin).
  - Any bit mismatch → err_cnt+1, saturating at 2^ERR_W-1.
  - On the first mismatch of the run: fail_valid=1 and fail_vec=vec_idx. Later mismatches do not overwrite fail_vec.
  - If vec_idx<7: vec_idx+1, drive outputs updated, counter reloaded → SETTLE.
  - If vec_idx==7 and (LOOPS==0 or loop counter<LOOPS-1): loop counter+1, vec_idx=0 → SETTLE.
  - Otherwise → DONE.
- DONE:
  - busy=0, done=1; drive outputs hold the last vector.
  - start=1 → same restart as from IDLE, with done cleared at that edge.
- start while busy is ignored.
- rst in any state returns every output and register to its reset value on the next edge, with no partial-run state retained.
- The block samples only in SAMPLE; DUT glitches during SETTLE are never counted.

## Timing
- start sampled high at edge k:
  - busy=1 and vector 0 appear at edge k.
  - The first SAMPLE cycle begins at edge k+SETTLE_CYCLES.
- Per vector: SETTLE_CYCLES+1 cycles. Per sweep: 8·(SETTLE_CYCLES+1).
- done=1 at edge k+LOOPS·8·(SETTLE_CYCLES+1); busy falls at the same edge.
- err_cnt, fail_valid and fail_vec update at the edge that ends the SAMPLE cycle. pass is valid from the done edge onward.
- rst and start high together: rst wins.

## Configuration
- FA_EXERCISER_SYNC_EN defined:
  - s_in and cout_in pass through a two-flop synchronizer before comparison.
  - The settle counter loads SETTLE_CYCLES+1 instead of SETTLE_CYCLES-1, adding 2 cycles per vector. Per-vector time becomes SETTLE_CYCLES+3.
  - Synchronizer flops reset to 0.
- FA_EXERCISER_SYNC_EN undefined: s_in and cout_in are compared directly in SAMPLE, with the timing above.

## Test plan
- Ideal behavioural FA, SETTLE_CYCLES=4, LOOPS=1, start at edge 10:
  - busy high over edges 10–49; done=1 at edge 50.
  - pass=1, err_cnt=0, fail_valid=0.
- FA with cout_in stuck at 0:
  - err_cnt=4, fail_vec=3, fail_valid=1, pass=0.
- FA with s_in inverted:
  - err_cnt=8, fail_vec=0.
- cout stuck at 0 with LOOPS=3, ERR_W=3:
  - err_cnt saturates at 7 (not 12); done at 120 cycles after start.
- rst asserted for one cycle while vec_idx=4 in SETTLE:
  - All outputs read 0 after the rst edge.
  - A following start sweeps from vec_idx=0 and completes normally.
- start pulsed while busy: no effect on vec_idx or timing.
- start pulsed in DONE with a prior err_cnt=4: err_cnt, done and fail_valid cleared at that edge, and a new run begins.
